// File: rtl/skut_deframer.sv
// skut_deframer
// Receive-side SKUT frame deframer. Hunts for the two-byte marker
// (SYNC0, SYNC1) in a strobed byte stream, then writes each 128-byte frame
// by address into an external ping-pong buffer pair. A flywheel keeps frame
// lock across up to MISS_LIMIT-1 consecutive bad markers.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   iStrobe    one-cycle sample strobe (at least 2 clk apart)
//   iData      sample byte, valid with iStrobe
//   oData      byte to buffer, valid with oWrEn
//   oAddr      frame position 0..127, valid with oWrEn
//   oWrEn      one-cycle buffer write pulse
//   oBufSel    buffer currently being written
//   oFrameRdy  one-cycle pulse: locked frame complete in buffer ~oBufSel
//   oLock      frame lock indicator
//   oMissCnt   saturating count of marker failures since reset
module skut_deframer #(
    parameter logic [7:0]  SYNC0      = 8'h7E,
    parameter logic [7:0]  SYNC1      = 8'h81,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iStrobe,
    input  logic [7:0] iData,
    output logic [7:0] oData,
    output logic [6:0] oAddr,
    output logic       oWrEn,
    output logic       oBufSel,
    output logic       oFrameRdy,
    output logic       oLock,
    output logic [7:0] oMissCnt
);

    localparam logic [3:0] MISS_LIM4 = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {S_HUNT, S_MARK, S_ACQ, S_CHK} state_t;

    state_t     state_q, state_d;
    logic [6:0] pos_q, pos_d;
    logic [3:0] run_q, run_d;
    logic       hdr_ok_q, hdr_ok_d;     // position-0 byte of this marker matched SYNC0
    logic [7:0] data_q, data_d;
    logic [6:0] addr_q, addr_d;
    logic       wren_q, wren_d;
    logic       done_q, done_d;         // locked frame finished; Rdy/toggle follow next cycle
    logic       rdy_q, rdy_d;
    logic       bufsel_q, bufsel_d;
    logic       lock_q, lock_d;
    logic [7:0] miss_q, miss_d;
    logic [3:0] run_inc;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        run_d    = run_q;
        hdr_ok_d = hdr_ok_q;
        data_d   = data_q;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        rdy_d    = done_q;
        bufsel_d = bufsel_q ^ done_q;
        lock_d   = lock_q;
        miss_d   = miss_q;
        run_inc  = run_q + 4'd1;

        if (iStrobe) begin
            data_d = iData;
            unique case (state_q)
                S_HUNT: begin
                    run_d = 4'd0;
                    if (iData == SYNC0) begin
                        wren_d  = 1'b1;
                        addr_d  = 7'd0;
                        state_d = S_MARK;
                    end
                end
                S_MARK: begin
                    if (iData == SYNC1) begin
                        wren_d  = 1'b1;
                        addr_d  = 7'd1;
                        pos_d   = 7'd2;
                        state_d = S_ACQ;
                    end else if (iData == SYNC0) begin
                        // Repeated SYNC0: treat the newest one as the marker start
                        wren_d = 1'b1;
                        addr_d = 7'd0;
                    end else begin
                        state_d = S_HUNT;
                    end
                end
                S_ACQ: begin
                    wren_d = 1'b1;
                    addr_d = pos_q;
                    pos_d  = pos_q + 7'd1;      // 127 wraps to 0 for the marker check
                    if (pos_q == 7'd127) begin
                        state_d = S_CHK;
                        done_d  = lock_q;       // first acquired frame is not announced
                    end
                end
                S_CHK: begin
                    wren_d = 1'b1;
                    addr_d = pos_q;
                    if (pos_q == 7'd0) begin
                        hdr_ok_d = (iData == SYNC0);
                        pos_d    = 7'd1;
                    end else if (hdr_ok_q && iData == SYNC1) begin
                        lock_d  = 1'b1;
                        run_d   = 4'd0;
                        pos_d   = 7'd2;
                        state_d = S_ACQ;
                    end else begin
                        miss_d = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
                        if (lock_q && run_inc < MISS_LIM4) begin
                            // Flywheel: assume alignment still holds
                            run_d   = run_inc;
                            pos_d   = 7'd2;
                            state_d = S_ACQ;
                        end else begin
                            // Failing byte is not re-examined for SYNC0
                            lock_d  = 1'b0;
                            run_d   = 4'd0;
                            pos_d   = 7'd0;
                            state_d = S_HUNT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_HUNT;
            pos_q    <= 7'd0;
            run_q    <= 4'd0;
            hdr_ok_q <= 1'b0;
            data_q   <= 8'd0;
            addr_q   <= 7'd0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
            bufsel_q <= 1'b0;
            lock_q   <= 1'b0;
            miss_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            run_q    <= run_d;
            hdr_ok_q <= hdr_ok_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
            bufsel_q <= bufsel_d;
            lock_q   <= lock_d;
            miss_q   <= miss_d;
        end
    end

    assign oData     = data_q;
    assign oAddr     = addr_q;
    assign oWrEn     = wren_q;
    assign oBufSel   = bufsel_q;
    assign oFrameRdy = rdy_q;
    assign oLock     = lock_q;
    assign oMissCnt  = miss_q;

endmodule

// File: doc/skut_deframer.md
# skut_deframer

Receive-side counterpart of the SKUT frame former. Takes the 8-bit SKUT sample stream recovered from the line (one byte per 320 kHz strobe), finds the two-byte frame marker, and maintains frame lock with a flywheel. Writes each 128-byte frame into an external ping-pong buffer pair by address, and signals when a complete, locked frame is ready for the downstream reader.

## Interface
Parameters:
- SYNC0, 8'h7E, marker byte at frame position 0
- SYNC1, 8'h81, marker byte at frame position 1
- MISS_LIMIT, 3, consecutive bad markers that drop lock (1..15)

Ports:
- clk  in  1  system clock, 80.64 MHz
- rst  in  1  asynchronous, active-low reset
- iStrobe  in  1  one-cycle sample strobe (320 kHz); strobes at least 2 clk apart
- iData  in  8  sample byte, valid when iStrobe=1
- oData  out  8  byte to buffer, valid with oWrEn
- oAddr  out  7  frame position 0..127, valid with oWrEn
- oWrEn  out  1  one-cycle buffer write pulse
- oBufSel  out  1  buffer being written (0/1); reader uses the other
- oFrameRdy  out  1  one-cycle pulse: locked frame finished in buffer ~oBufSel
- oLock  out  1  frame lock indicator
- oMissCnt  out  8  total marker failures since reset, saturating at 255

## Operation
- Frame: 128 bytes, position 0 = SYNC0, position 1 = SYNC1, positions 2..127 payload. All 128 positions are written, so the buffer matches the former's image.
- Position counter pos (7 bit) and all state advance only on iStrobe.
- States:
  - HUNT: iData==SYNC0 -> write addr 0, go MARK; else no write.
  - MARK: iData==SYNC1 -> write addr 1, pos=2, go ACQ. iData==SYNC0 -> write addr 0, stay MARK. Otherwise -> HUNT, no write.
  - ACQ: write iData at pos, then pos+1. The write at pos=127 completes the frame, then go CHK with pos=0.
  - CHK: write iData at pos 0/1. The marker test is evaluated at the pos-1 strobe and passes iff pos0==SYNC0 and pos1==SYNC1.
    - Pass: oLock=1, miss run cleared, go ACQ with pos=2.
    - Fail: oMissCnt+1 (saturating) and miss run+1.
    - Fail while unlocked -> HUNT.
    - Fail while locked with run<MISS_LIMIT -> flywheel: stay aligned, go ACQ with pos=2.
    - Fail while locked with run==MISS_LIMIT -> oLock=0, HUNT. The partial frame is abandoned, oBufSel is unchanged, and the failing sample is not re-examined for SYNC0.
- Frame completion (pos=127 written):
  - oLock=1 -> toggle oBufSel and pulse oFrameRdy.
  - oLock=0 (first acquired frame) -> no pulse, no toggle; the next frame overwrites the same buffer.
- Lock therefore rises at the first marker following a complete acquired frame. The first oFrameRdy comes at the end of that second frame.
- Miss run is a 4-bit counter, cleared on pass and on entry to HUNT.

## Timing
- Reset (rst=0, asynchronous): state HUNT, pos=0, miss run=0; oData=0, oAddr=0, oWrEn=0, oBufSel=0, oFrameRdy=0, oLock=0, oMissCnt=0. Outputs are held until the first strobe after rst release.
- Write latency: iStrobe at cycle N -> oWrEn=1 with registered oData/oAddr at cycle N+1, for exactly one cycle.
- oFrameRdy and the oBufSel toggle occur at cycle N+2 after the pos-127 strobe, one cycle after its oWrEn. oBufSel is stable otherwise.
- oLock and oMissCnt update at N+1 of the pos-1 strobe.
- iStrobe is ignored while rst=0. Reset mid-frame abandons the frame with no oFrameRdy.
- No write occurs on cycles without a preceding strobe. oWrEn never lasts more than 1 cycle.

## Test plan
- Clean stream: three back-to-back frames (7E 81, payload 00..7D) -> first frame written to buffer 0 with no Rdy. oLock=1 at pos 1 of frame 2. oFrameRdy at end of frame 2 with oBufSel 0->1, and at end of frame 3 with oBufSel 1->0. oMissCnt=0.
- False marker: bytes 7E 7E 81 then payload -> addr 0 is written twice, addr 1 = 81, acquisition proceeds from pos 2.
- Flywheel: locked stream, markers of two consecutive frames corrupted to 00 00 -> oMissCnt=2, oLock stays 1, oFrameRdy continues each frame. A good marker clears the miss run.
- Loss of lock: MISS_LIMIT=3, three consecutive bad markers -> oLock falls at the third, no further writes, no Rdy, oBufSel unchanged, HUNT. A clean stream re-locks after one frame.
- Reset mid-frame: rst low at pos 60 of a locked frame -> all outputs 0 immediately, no oFrameRdy. After release, acquisition restarts on the next SYNC0.
- Saturation: 300 unlocked marker failures (7E 81 + 126 bytes followed by a bad marker, repeated) -> oMissCnt stops at 255.
